noc_axi_id_remap: RTL and testbench

- Bidirectional AXI ID compressor between a wide-ID master (tile crossbar or DMA, SlvIdW bits) and the mesh NoC data port (MstIdW bits, default AXI_NOC_ID_W = 4).
- Keeps independent read and write remap tables, each MaxUniqIds entries deep.
- Maps each in-flight wide ID onto a table index used as the NoC ID and restores the wide ID on R/B responses.
- Per-entry outstanding counters preserve AXI same-ID ordering; the block stalls AR/AW when no mapping is available.

---
 rtl/noc_axi_id_remap.sv | 349 ++++++++++++++++++++++++++++++++++
 tb/tb_noc_axi_id_remap.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_axi_id_remap.sv
// AXI ID compressor between a wide-ID upstream master and the mesh NoC data port.
// Independent read/write remap tables map in-flight wide IDs onto NoC table indices.
package noc_axi_id_remap_pkg;

  localparam int unsigned AXI_NOC_ID_W = 4;
  localparam int unsigned AXI_SLV_ID_W = 6;
  localparam int unsigned AXI_ADDR_W   = 32;
  localparam int unsigned AXI_DATA_W   = 32;
  localparam int unsigned AXI_STRB_W   = AXI_DATA_W / 8;

  typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
  typedef logic [AXI_DATA_W-1:0] axi_data_t;
  typedef logic [AXI_STRB_W-1:0] axi_strb_t;

  typedef struct packed {
    axi_data_t data;
    axi_strb_t strb;
    logic      last;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_SLV_ID_W-1:0] id;
    axi_addr_t               addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } slv_ar_t;

  typedef struct packed {
    logic [AXI_SLV_ID_W-1:0] id;
    axi_addr_t               addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic [5:0]              atop;
  } slv_aw_t;

  typedef struct packed {
    logic [AXI_SLV_ID_W-1:0] id;
    axi_data_t               data;
    logic [1:0]              resp;
    logic                    last;
  } slv_r_t;

  typedef struct packed {
    logic [AXI_SLV_ID_W-1:0] id;
    logic [1:0]              resp;
  } slv_b_t;

  typedef struct packed {
    logic [AXI_NOC_ID_W-1:0] id;
    axi_addr_t               addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } noc_ar_t;

  typedef struct packed {
    logic [AXI_NOC_ID_W-1:0] id;
    axi_addr_t               addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic [5:0]              atop;
  } noc_aw_t;

  typedef struct packed {
    logic [AXI_NOC_ID_W-1:0] id;
    axi_data_t               data;
    logic [1:0]              resp;
    logic                    last;
  } noc_r_t;

  typedef struct packed {
    logic [AXI_NOC_ID_W-1:0] id;
    logic [1:0]              resp;
  } noc_b_t;

  typedef struct packed {
    slv_aw_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    slv_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } slv_axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    slv_b_t b;
    logic   r_valid;
    slv_r_t r;
  } slv_axi_rsp_t;

  typedef struct packed {
    noc_aw_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    noc_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } noc_axi_data_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    noc_b_t b;
    logic   r_valid;
    noc_r_t r;
  } noc_axi_data_rsp_t;

endpackage

// One direction's remap table: lookup/allocate on the address channel, restore on responses.
module noc_axi_id_remap_table #(
  parameter int unsigned SlvIdW       = 6,
  parameter int unsigned MstIdW       = 4,
  parameter int unsigned MaxUniqIds   = 16,
  parameter int unsigned MaxTxnsPerId = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid,
  input  logic              req_ready,
  input  logic [SlvIdW-1:0] req_id,
  output logic              issue_c,
  output logic [MstIdW-1:0] idx_c,
  input  logic              rsp_valid,
  input  logic              rsp_ready,
  input  logic              rsp_last,
  input  logic [MstIdW-1:0] rsp_idx,
  output logic [SlvIdW-1:0] rsp_slv_id_c,
  output logic              busy_o
);

  localparam int unsigned CntW = $clog2(MaxTxnsPerId + 1);

  logic [MaxUniqIds-1:0] valid_q, valid_d;
  logic [SlvIdW-1:0]     slv_id_q [MaxUniqIds];
  logic [SlvIdW-1:0]     slv_id_d [MaxUniqIds];
  logic [CntW-1:0]       cnt_q    [MaxUniqIds];
  logic [CntW-1:0]       cnt_d    [MaxUniqIds];
  logic                  busy_q;

  logic                  hit, free;
  logic [MstIdW-1:0]     hit_idx, free_idx;
  logic [CntW-1:0]       hit_cnt;
  logic                  rsp_hit, cnt_bad;
  logic                  inc, dec;
  logic [MaxUniqIds-1:0] inc_vec, dec_vec;

  // Lookup against registered state only: an entry freed this cycle is not reusable until next.
  always_comb begin
    hit          = 1'b0;
    hit_idx      = '0;
    hit_cnt      = '0;
    free         = 1'b0;
    free_idx     = '0;
    rsp_hit      = 1'b0;
    rsp_slv_id_c = '0;
    for (int unsigned i = 0; i < MaxUniqIds; i++) begin
      if (valid_q[i] && (slv_id_q[i] == req_id) && !hit) begin
        hit     = 1'b1;
        hit_idx = MstIdW'(i);
        hit_cnt = cnt_q[i];
      end
      if (!valid_q[i] && !free) begin
        free     = 1'b1;
        free_idx = MstIdW'(i);
      end
      if (MstIdW'(i) == rsp_idx) begin
        rsp_hit      = valid_q[i];
        rsp_slv_id_c = slv_id_q[i];
      end
    end
    issue_c = hit ? (hit_cnt < CntW'(MaxTxnsPerId)) : free;
    idx_c   = hit ? hit_idx : free_idx;
  end

  // Entry update; a simultaneous increment and decrement on one entry cancel out.
  always_comb begin
    inc      = req_valid && req_ready && issue_c;
    dec      = rsp_valid && rsp_ready && rsp_last;
    valid_d  = valid_q;
    slv_id_d = slv_id_q;
    cnt_d    = cnt_q;
    inc_vec  = '0;
    dec_vec  = '0;
    cnt_bad  = 1'b0;
    for (int unsigned i = 0; i < MaxUniqIds; i++) begin
      inc_vec[i] = inc && (idx_c == MstIdW'(i));
      dec_vec[i] = dec && (rsp_idx == MstIdW'(i));
      if (cnt_q[i] > CntW'(MaxTxnsPerId)) cnt_bad = 1'b1;
      if (inc_vec[i] && !dec_vec[i]) begin
        if (!valid_q[i]) begin
          valid_d[i]  = 1'b1;
          slv_id_d[i] = req_id;
          cnt_d[i]    = CntW'(1);
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end else if (dec_vec[i] && !inc_vec[i]) begin
        if (cnt_q[i] == '0) cnt_bad = 1'b1;
        cnt_d[i] = cnt_q[i] - CntW'(1);
        if (cnt_q[i] == CntW'(1)) valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      busy_q  <= 1'b0;
      for (int unsigned i = 0; i < MaxUniqIds; i++) begin
        slv_id_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      slv_id_q <= slv_id_d;
      cnt_q    <= cnt_d;
      busy_q   <= |valid_d;
    end
  end

  assign busy_o = busy_q;

  a_rsp_valid_entry : assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_valid |-> rsp_hit);
  a_cnt_range : assert property (@(posedge clk_i) disable iff (!rst_ni) !cnt_bad);
  a_params : assert property (@(posedge clk_i)
    (MstIdW < SlvIdW) && (MaxUniqIds <= (2 ** MstIdW)) && (MaxTxnsPerId > 0));

endmodule

// Top: read table on AR/R, write table on AW/B, W passes straight through.
module noc_axi_id_remap
  import noc_axi_id_remap_pkg::*;
#(
  parameter int unsigned SlvIdW       = AXI_SLV_ID_W,
  parameter int unsigned MstIdW       = AXI_NOC_ID_W,
  parameter int unsigned MaxUniqIds   = 16,
  parameter int unsigned MaxTxnsPerId = 8,
  parameter type slv_req_t = slv_axi_req_t,
  parameter type slv_rsp_t = slv_axi_rsp_t,
  parameter type mst_req_t = noc_axi_data_req_t,
  parameter type mst_rsp_t = noc_axi_data_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  slv_req_t slv_req_i,
  output slv_rsp_t slv_rsp_o,
  output mst_req_t mst_req_o,
  input  mst_rsp_t mst_rsp_i,
  output logic     rd_busy_o,
  output logic     wr_busy_o
);

  logic              rd_issue_c, wr_issue_c;
  logic [MstIdW-1:0] rd_idx_c, wr_idx_c;
  logic [SlvIdW-1:0] rd_rsp_id_c, wr_rsp_id_c;

  noc_axi_id_remap_table #(
    .SlvIdW(SlvIdW), .MstIdW(MstIdW), .MaxUniqIds(MaxUniqIds), .MaxTxnsPerId(MaxTxnsPerId)
  ) u_rd_table (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid    (slv_req_i.ar_valid),
    .req_ready    (mst_rsp_i.ar_ready),
    .req_id       (slv_req_i.ar.id),
    .issue_c      (rd_issue_c),
    .idx_c        (rd_idx_c),
    .rsp_valid    (mst_rsp_i.r_valid),
    .rsp_ready    (slv_req_i.r_ready),
    .rsp_last     (mst_rsp_i.r.last),
    .rsp_idx      (mst_rsp_i.r.id),
    .rsp_slv_id_c (rd_rsp_id_c),
    .busy_o       (rd_busy_o)
  );

  noc_axi_id_remap_table #(
    .SlvIdW(SlvIdW), .MstIdW(MstIdW), .MaxUniqIds(MaxUniqIds), .MaxTxnsPerId(MaxTxnsPerId)
  ) u_wr_table (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid    (slv_req_i.aw_valid),
    .req_ready    (mst_rsp_i.aw_ready),
    .req_id       (slv_req_i.aw.id),
    .issue_c      (wr_issue_c),
    .idx_c        (wr_idx_c),
    .rsp_valid    (mst_rsp_i.b_valid),
    .rsp_ready    (slv_req_i.b_ready),
    .rsp_last     (1'b1),
    .rsp_idx      (mst_rsp_i.b.id),
    .rsp_slv_id_c (wr_rsp_id_c),
    .busy_o       (wr_busy_o)
  );

  // Request side: swap IDs, gate valid on a usable mapping.
  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw.id    = wr_idx_c;
    mst_req_o.aw.addr  = slv_req_i.aw.addr;
    mst_req_o.aw.len   = slv_req_i.aw.len;
    mst_req_o.aw.size  = slv_req_i.aw.size;
    mst_req_o.aw.burst = slv_req_i.aw.burst;
    mst_req_o.aw.atop  = slv_req_i.aw.atop;
    mst_req_o.aw_valid = slv_req_i.aw_valid && wr_issue_c;
    mst_req_o.w        = slv_req_i.w;
    mst_req_o.w_valid  = slv_req_i.w_valid;
    mst_req_o.b_ready  = slv_req_i.b_ready;
    mst_req_o.ar.id    = rd_idx_c;
    mst_req_o.ar.addr  = slv_req_i.ar.addr;
    mst_req_o.ar.len   = slv_req_i.ar.len;
    mst_req_o.ar.size  = slv_req_i.ar.size;
    mst_req_o.ar.burst = slv_req_i.ar.burst;
    mst_req_o.ar_valid = slv_req_i.ar_valid && rd_issue_c;
    mst_req_o.r_ready  = slv_req_i.r_ready;
  end

  // Response side: restore wide IDs from the tables.
  always_comb begin
    slv_rsp_o          = '0;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready && wr_issue_c;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready && rd_issue_c;
    slv_rsp_o.w_ready  = mst_rsp_i.w_ready;
    slv_rsp_o.b_valid  = mst_rsp_i.b_valid;
    slv_rsp_o.b.id     = wr_rsp_id_c;
    slv_rsp_o.b.resp   = mst_rsp_i.b.resp;
    slv_rsp_o.r_valid  = mst_rsp_i.r_valid;
    slv_rsp_o.r.id     = rd_rsp_id_c;
    slv_rsp_o.r.data   = mst_rsp_i.r.data;
    slv_rsp_o.r.resp   = mst_rsp_i.r.resp;
    slv_rsp_o.r.last   = mst_rsp_i.r.last;
  end

  a_no_atop : assert property (@(posedge clk_i) disable iff (!rst_ni)
    slv_req_i.aw_valid |-> (slv_req_i.aw.atop == '0));

endmodule

// File: tb/tb_noc_axi_id_remap.sv
// Randomized bench for noc_axi_id_remap against an ID-ownership reference model.
module tb_noc_axi_id_remap;
  import noc_axi_id_remap_pkg::*;

  localparam int NE   = 16;
  localparam int MAXT = 8;

  logic              clk;
  logic              rst_n;
  slv_axi_req_t      slv_req;
  slv_axi_rsp_t      slv_rsp;
  noc_axi_data_req_t mst_req;
  noc_axi_data_rsp_t mst_rsp;
  logic              rd_busy, wr_busy;

  noc_axi_id_remap dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .slv_req_i (slv_req),
    .slv_rsp_o (slv_rsp),
    .mst_req_o (mst_req),
    .mst_rsp_i (mst_rsp),
    .rd_busy_o (rd_busy),
    .wr_busy_o (wr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: which wide ID owns each NoC ID, and how many transactions are outstanding on it.
  int owner [2][NE];
  int outst [2][NE];
  typedef struct {
    int idx;
    int wid;
    int beats;
  } txn_t;
  txn_t rq[$];
  txn_t bq[$];

  bit          ar_v, aw_v, w_v;
  bit          ar_rdy, aw_rdy, w_rdy, r_rdy, b_rdy;
  int          ar_id, aw_id, ar_len;
  logic [31:0] ar_addr, aw_addr, w_data;
  int          r_pick = -1;
  int          b_pick = -1;
  bit          ar_fired, aw_fired;

  function automatic void lookup(input int d, input int id, output bit ok, output int idx);
    ok  = 1'b0;
    idx = -1;
    for (int i = 0; i < NE; i++)
      if (owner[d][i] == id) begin
        ok  = (outst[d][i] < MAXT);
        idx = i;
        return;
      end
    for (int i = 0; i < NE; i++)
      if (owner[d][i] < 0) begin
        ok  = 1'b1;
        idx = i;
        return;
      end
  endfunction

  function automatic bit any_owned(input int d);
    for (int i = 0; i < NE; i++) if (owner[d][i] >= 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NE; i++) begin
        owner[d][i] = -1;
        outst[d][i] = 0;
      end
    rq.delete();
    bq.delete();
  endfunction

  // One clock cycle: drive, check combinational outputs, then advance the model at the edge.
  task automatic tick();
    bit   rok, wok, r_v, b_v, r_fire, b_fire, rbusy_exp, wbusy_exp;
    int   ridx, widx;
    txn_t rt, bt;
    lookup(0, ar_id, rok, ridx);
    lookup(1, aw_id, wok, widx);
    r_v = (r_pick >= 0);
    b_v = (b_pick >= 0);
    rt  = '{0, 0, 0};
    bt  = '{0, 0, 0};
    if (r_v) rt = rq[r_pick];
    if (b_v) bt = bq[b_pick];
    rbusy_exp = any_owned(0);
    wbusy_exp = any_owned(1);

    @(negedge clk);
    slv_req.ar_valid = ar_v;
    slv_req.ar.id    = 6'(ar_id);
    slv_req.ar.addr  = ar_addr;
    slv_req.ar.len   = 8'(ar_len);
    slv_req.ar.size  = 3'd2;
    slv_req.ar.burst = 2'b01;
    slv_req.aw_valid = aw_v;
    slv_req.aw.id    = 6'(aw_id);
    slv_req.aw.addr  = aw_addr;
    slv_req.aw.len   = 8'd0;
    slv_req.aw.size  = 3'd2;
    slv_req.aw.burst = 2'b01;
    slv_req.aw.atop  = 6'd0;
    slv_req.w_valid  = w_v;
    slv_req.w.data   = w_data;
    slv_req.w.strb   = 4'hf;
    slv_req.w.last   = 1'b1;
    slv_req.r_ready  = r_rdy;
    slv_req.b_ready  = b_rdy;
    mst_rsp.ar_ready = ar_rdy;
    mst_rsp.aw_ready = aw_rdy;
    mst_rsp.w_ready  = w_rdy;
    mst_rsp.r_valid  = r_v;
    mst_rsp.r.id     = 4'(rt.idx);
    mst_rsp.r.data   = $urandom;
    mst_rsp.r.resp   = 2'b00;
    mst_rsp.r.last   = r_v && (rt.beats == 1);
    mst_rsp.b_valid  = b_v;
    mst_rsp.b.id     = 4'(bt.idx);
    mst_rsp.b.resp   = 2'b00;
    #1;
    chk("ar_valid", mst_req.ar_valid, ar_v && rok);
    if (ar_v) begin
      chk("ar_ready", slv_rsp.ar_ready, rok && ar_rdy);
      if (rok) begin
        chk("ar_id", mst_req.ar.id, ridx);
        chk("ar_addr", mst_req.ar.addr, ar_addr);
      end
    end
    chk("aw_valid", mst_req.aw_valid, aw_v && wok);
    if (aw_v) begin
      chk("aw_ready", slv_rsp.aw_ready, wok && aw_rdy);
      if (wok) chk("aw_id", mst_req.aw.id, widx);
    end
    chk("w_data", mst_req.w.data, w_data);
    chk("w_ready", slv_rsp.w_ready, w_rdy);
    if (r_v) begin
      chk("r_id", slv_rsp.r.id, rt.wid);
      chk("r_last", slv_rsp.r.last, rt.beats == 1);
      chk("r_ready", mst_req.r_ready, r_rdy);
    end
    if (b_v) chk("b_id", slv_rsp.b.id, bt.wid);
    chk("rd_busy", rd_busy, rbusy_exp);
    chk("wr_busy", wr_busy, wbusy_exp);

    @(posedge clk);
    ar_fired = ar_v && rok && ar_rdy;
    aw_fired = aw_v && wok && aw_rdy;
    r_fire   = r_v && r_rdy;
    b_fire   = b_v && b_rdy;
    if (ar_fired) begin
      owner[0][ridx] = ar_id;
      outst[0][ridx]++;
    end
    if (aw_fired) begin
      owner[1][widx] = aw_id;
      outst[1][widx]++;
    end
    if (r_fire) begin
      if (rt.beats == 1) begin
        outst[0][rt.idx]--;
        if (outst[0][rt.idx] == 0) owner[0][rt.idx] = -1;
        rq.delete(r_pick);
        r_pick = -1;
      end else begin
        rt.beats--;
        rq[r_pick] = rt;
      end
    end
    if (b_fire) begin
      outst[1][bt.idx]--;
      if (outst[1][bt.idx] == 0) owner[1][bt.idx] = -1;
      bq.delete(b_pick);
      b_pick = -1;
    end
    if (ar_fired) rq.push_back('{ridx, ar_id, ar_len + 1});
    if (aw_fired) bq.push_back('{widx, aw_id, 1});
  endtask

  task automatic rand_cycle(input int id_lo, input int id_span, input int ar_pct, input int rsp_pct);
    if (!(ar_v && !ar_fired)) begin
      ar_v    = ($urandom_range(99) < ar_pct);
      ar_id   = id_lo + $urandom_range(id_span - 1);
      ar_addr = $urandom;
      ar_len  = $urandom_range(3);
    end
    if (!(aw_v && !aw_fired)) begin
      aw_v    = ($urandom_range(99) < ar_pct);
      aw_id   = id_lo + $urandom_range(id_span - 1);
      aw_addr = $urandom;
    end
    ar_rdy = ($urandom_range(3) != 0);
    aw_rdy = ($urandom_range(3) != 0);
    r_rdy  = ($urandom_range(3) != 0);
    b_rdy  = ($urandom_range(3) != 0);
    w_v    = 1'($urandom);
    w_rdy  = 1'($urandom);
    w_data = $urandom;
    if (r_pick < 0 && rq.size() > 0 && $urandom_range(99) < rsp_pct)
      r_pick = $urandom_range(rq.size() - 1);
    if (b_pick < 0 && bq.size() > 0 && $urandom_range(99) < rsp_pct)
      b_pick = $urandom_range(bq.size() - 1);
    tick();
  endtask

  task automatic idle_drive();
    ar_v = 0; aw_v = 0; w_v = 0;
    ar_rdy = 1; aw_rdy = 1; w_rdy = 0; r_rdy = 1; b_rdy = 1;
    ar_len = 0; ar_addr = 32'h1000; aw_addr = 32'h2000; w_data = 32'h0;
    ar_fired = 0; aw_fired = 0;
    r_pick = -1; b_pick = -1;
  endtask

  task automatic do_reset();
    idle_drive();
    @(negedge clk);
    rst_n   = 1'b0;
    slv_req = '0;
    mst_rsp = '0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_rd_busy", rd_busy, 1'b0);
    chk("rst_wr_busy", wr_busy, 1'b0);
  endtask

  task automatic drain();
    ar_v = 0;
    aw_v = 0;
    for (int k = 0; k < 500 && (rq.size() > 0 || bq.size() > 0 || r_pick >= 0); k++) begin
      r_rdy = 1;
      b_rdy = 1;
      if (r_pick < 0 && rq.size() > 0) r_pick = 0;
      if (b_pick < 0 && bq.size() > 0) b_pick = 0;
      tick();
    end
    tick();
    #1;
    chk("drain_rd_busy", rd_busy, 1'b0);
    chk("drain_wr_busy", wr_busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    do_reset();

    // Single read 0x2A maps to NoC ID 0 and comes back restored.
    ar_v = 1; ar_id = 'h2A; tick();
    ar_v = 0; r_pick = 0; tick();
    tick();
    #1 chk("single_busy_clear", rd_busy, 1'b0);

    // Sixteen distinct IDs fill the table; a 17th stalls until an entry frees.
    for (int i = 0; i < NE; i++) begin
      ar_v = 1; ar_id = i + 1; tick();
    end
    ar_id = 'h3F;
    tick();
    tick();
    r_pick = 5; tick();
    tick();
    #1 chk("full_reuse_fired", ar_fired, 1'b1);
    drain();

    // Per-ID outstanding limit: 9th read with the same ID waits for one response.
    for (int i = 0; i < MAXT + 2; i++) begin
      ar_v = 1; ar_id = 'h05; tick();
    end
    r_pick = 0; tick();
    tick();
    drain();

    // Concurrent write and read with the same wide ID use independent tables.
    aw_v = 1; aw_id = 'h11; ar_v = 1; ar_id = 'h11; tick();
    aw_v = 0; ar_v = 0;
    for (int i = 0; i < 4; i++) begin
      w_v = 1; w_rdy = 1; w_data = 32'hA000 + i; tick();
    end
    w_v = 0; b_pick = 0; r_pick = 0; tick();
    drain();

    // Same-cycle issue and last response on one entry leaves its count unchanged.
    for (int i = 0; i < 3; i++) begin
      ar_v = 1; ar_id = 'h07; tick();
    end
    r_pick = 0; tick();
    for (int i = 0; i < 6; i++) tick();
    drain();

    for (int n = 0; n < 1500; n++) rand_cycle(0, 64, 60, 20);
    for (int n = 0; n < 1500; n++) rand_cycle(4, 2, 70, 10);
    for (int n = 0; n < 1500; n++) rand_cycle(0, 20, 50, 40);

    // Reset with mappings live, then the first new ID starts again at index 0.
    for (int n = 0; n < 40; n++) rand_cycle(0, 64, 90, 0);
    #1 chk("pre_reset_busy", rd_busy, 1'b1);
    do_reset();
    ar_v = 1; ar_id = 'h33; tick();
    ar_v = 0;
    for (int n = 0; n < 1000; n++) rand_cycle(0, 64, 50, 30);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
